// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encodings and port constants for mem_arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    localparam logic ARB_CPU = 1'b0;
    localparam logic ARB_AUX = 1'b1;

    localparam int MEM_LATENCY_DEFAULT = 1;

    // Port index to one-hot grant vector.
    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational grant selector; policy set by MEM_ARB_RR_EN
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_served,
    output logic [1:0] gnt
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores history; the input stays for a uniform interface.
    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

    // One-hot grant: a lone requester wins, a tie follows the configured policy.
    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
            gnt = port_onehot(~last_served);
`else
            gnt = port_onehot(ARB_CPU);
`endif
        end else if (req0) begin
            gnt = port_onehot(ARB_CPU);
        end else if (req1) begin
            gnt = port_onehot(ARB_AUX);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter for a single-port sync RAM; MEM_ARB_RR_EN selects round-robin
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [WORD_SIZE-1:0] addr0,
    input  logic [WORD_SIZE-1:0] wdata0,
    output logic                 done0,
    output logic [WORD_SIZE-1:0] rdata0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [WORD_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata1,
    output logic                 done1,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic [1:0]           gnt,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    // WAIT lasts MEM_LATENCY-1 cycles; the counter is loaded on leaving ISSUE.
    localparam logic [2:0] WAIT_LOAD = 3'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

    arb_state_t           state, state_n;
    logic [2:0]           cnt_q;
    logic                 owner_q;
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata0_q;
    logic [WORD_SIZE-1:0] rdata1_q;
    logic                 last_served;
    logic [1:0]           pick_gnt;
    logic                 accept;

    arb_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_served (last_served),
        .gnt         (pick_gnt)
    );

    assign accept = (state == ARB_IDLE) && (pick_gnt != 2'b00);

`ifdef MEM_ARB_RR_EN
    // Remember who was served last so the next tie goes the other way.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_served <= ARB_AUX;
        end else if (accept) begin
            last_served <= pick_gnt[1];
        end
    end
`else
    assign last_served = ARB_AUX;
`endif

    // State register, wait counter, latched request and per-port read-data holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB_IDLE;
            cnt_q    <= '0;
            owner_q  <= ARB_CPU;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                owner_q <= pick_gnt[1];
                we_q    <= pick_gnt[1] ? we1    : we0;
                addr_q  <= pick_gnt[1] ? addr1  : addr0;
                wdata_q <= pick_gnt[1] ? wdata1 : wdata0;
            end
            if (state == ARB_ISSUE) begin
                cnt_q <= WAIT_LOAD;
            end else if (state == ARB_WAIT && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (state == ARB_DONE) begin
                if (owner_q == ARB_AUX) begin
                    rdata1_q <= mem_rdata;
                end else begin
                    rdata0_q <= mem_rdata;
                end
            end
        end
    end

    // Next-state and all outputs, decoded from the current state and latched request.
    always_comb begin
        state_n   = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done0     = 1'b0;
        done1     = 1'b0;
        gnt       = 2'b00;
        rdata0    = rdata0_q;
        rdata1    = rdata1_q;
        case (state)
            ARB_IDLE: begin
                if (pick_gnt != 2'b00) begin
                    state_n = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                gnt       = port_onehot(owner_q);
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                state_n   = (MEM_LATENCY > 1) ? ARB_WAIT : ARB_DONE;
            end
            ARB_WAIT: begin
                gnt = port_onehot(owner_q);
                if (cnt_q == 3'd0) begin
                    state_n = ARB_DONE;
                end
            end
            ARB_DONE: begin
                gnt     = port_onehot(owner_q);
                state_n = ARB_IDLE;
                if (owner_q == ARB_AUX) begin
                    done1  = 1'b1;
                    rdata1 = mem_rdata;
                end else begin
                    done0  = 1'b1;
                    rdata0 = mem_rdata;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter at latencies 1, 3 and 7
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        ram_init;
    logic        rstn_v    [3];
    logic        req0_v    [3];
    logic        we0_v     [3];
    logic [15:0] addr0_v   [3];
    logic [15:0] wdata0_v  [3];
    logic        done0_v   [3];
    logic [15:0] rdata0_v  [3];
    logic        req1_v    [3];
    logic        we1_v     [3];
    logic [15:0] addr1_v   [3];
    logic [15:0] wdata1_v  [3];
    logic        done1_v   [3];
    logic [15:0] rdata1_v  [3];
    logic [1:0]  gnt_v     [3];
    logic        mem_en_v  [3];
    logic        mem_we_v  [3];
    logic [15:0] mem_addr_v  [3];
    logic [15:0] mem_wdata_v [3];
    logic [15:0] mem_rdata_v [3];

    int total = 0;
    int bad   = 0;

    logic [15:0] ref_mem  [3][256];
    logic        ref_last [3];

    function automatic logic [15:0] init_word(int i);
        if (i == 16) return 16'hBEEF;
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 7);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 7);
        logic [15:0] ram  [256];
        logic [15:0] pipe [8];

        mem_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(LAT)) dut (
            .clk       (clk),
            .reset_n   (rstn_v[g]),
            .req0      (req0_v[g]),
            .we0       (we0_v[g]),
            .addr0     (addr0_v[g]),
            .wdata0    (wdata0_v[g]),
            .done0     (done0_v[g]),
            .rdata0    (rdata0_v[g]),
            .req1      (req1_v[g]),
            .we1       (we1_v[g]),
            .addr1     (addr1_v[g]),
            .wdata1    (wdata1_v[g]),
            .done1     (done1_v[g]),
            .rdata1    (rdata1_v[g]),
            .gnt       (gnt_v[g]),
            .mem_en    (mem_en_v[g]),
            .mem_we    (mem_we_v[g]),
            .mem_addr  (mem_addr_v[g]),
            .mem_wdata (mem_wdata_v[g]),
            .mem_rdata (mem_rdata_v[g])
        );

        // RAM model: data is valid only in the cycle LAT after the strobe.
        always @(posedge clk) begin
            if (ram_init) begin
                for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            end else if (mem_en_v[g] && mem_we_v[g]) begin
                ram[mem_addr_v[g][7:0]] <= mem_wdata_v[g];
            end
            if (mem_en_v[g])
                pipe[0] <= mem_we_v[g] ? mem_wdata_v[g] : ram[mem_addr_v[g][7:0]];
            else
                pipe[0] <= 16'hDEAD;
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata_v[g] = pipe[LAT-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input int k, input string tag);
        check({tag, "_gnt"},   32'(gnt_v[k]), 0);
        check({tag, "_done"},  {30'd0, done1_v[k], done0_v[k]}, 0);
        check({tag, "_en_we"}, {30'd0, mem_en_v[k], mem_we_v[k]}, 0);
        check({tag, "_addr"},  32'(mem_addr_v[k]), 0);
        check({tag, "_wdata"}, 32'(mem_wdata_v[k]), 0);
        check({tag, "_rdata"}, {rdata1_v[k], rdata0_v[k]}, 0);
    endtask

    task automatic set_port(input int k, input int port, input logic req, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata);
        if (port == 0) begin
            req0_v[k] = req; we0_v[k] = we; addr0_v[k] = addr; wdata0_v[k] = wdata;
        end else begin
            req1_v[k] = req; we1_v[k] = we; addr1_v[k] = addr; wdata1_v[k] = wdata;
        end
    endtask

    // One transaction from a single requester, started on a negedge with the arbiter idle.
    task automatic txn(input int k, input int port, input logic we,
                       input logic [15:0] addr, input logic [15:0] wdata);
        logic [15:0] exp_rd;
        logic [15:0] got_rd;
        int n = 0;
        int wecnt = 0;
        bit got = 0;
        exp_rd = we ? wdata : ref_mem[k][addr[7:0]];
        set_port(k, port, 1'b1, we, addr, wdata);
        while (n < 20 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (mem_we_v[k]) wecnt++;
            if (n == 1) begin
                check("issue_en", 32'(mem_en_v[k]), 1);
                check("issue_addr", 32'(mem_addr_v[k]), 32'(addr));
                if (we) check("issue_wdata", 32'(mem_wdata_v[k]), 32'(wdata));
                set_port(k, port, 1'b1, ~we, ~addr, ~wdata);
            end
            check("txn_gnt", 32'(gnt_v[k]), (port == 1) ? 2 : 1);
            if (done0_v[k] || done1_v[k]) got = 1;
        end
        got_rd = (port == 1) ? rdata1_v[k] : rdata0_v[k];
        check("done_latency", n, 1 + lat_of(k));
        check("done_port", {30'd0, done1_v[k], done0_v[k]}, (port == 1) ? 2 : 1);
        check("done_rdata", 32'(got_rd), 32'(exp_rd));
        check("we_cycles", wecnt, 32'(we));
        set_port(k, port, 1'b0, 1'b0, 16'h0, 16'h0);
        if (we) ref_mem[k][addr[7:0]] = wdata;
        ref_last[k] = (port == 1);
        @(posedge clk);
        @(negedge clk);
        got_rd = (port == 1) ? rdata1_v[k] : rdata0_v[k];
        check("idle_gnt", 32'(gnt_v[k]), 0);
        check("rdata_hold", 32'(got_rd), 32'(exp_rd));
    endtask

    // Both ports request reads continuously until ndone completions are seen.
    task automatic tie(input int k, input int ndone);
        logic [15:0] a [2];
        int cyc = 0, since = 0, got = 0, p, expw, lat;
        lat = lat_of(k);
        a[0] = 16'($urandom);
        a[1] = 16'($urandom);
        set_port(k, 0, 1'b1, 1'b0, a[0], 16'h0);
        set_port(k, 1, 1'b1, 1'b0, a[1], 16'h0);
        while (got < ndone && cyc < 200) begin
            @(posedge clk);
            cyc++;
            since++;
            @(negedge clk);
            check("tie_excl", 32'(done0_v[k] & done1_v[k]), 0);
            if (done0_v[k] || done1_v[k]) begin
                p = done1_v[k] ? 1 : 0;
`ifdef MEM_ARB_RR_EN
                expw = ref_last[k] ? 0 : 1;
`else
                expw = 0;
`endif
                check("tie_port", p, expw);
                check("tie_gap", since, (got == 0) ? 1 + lat : 2 + lat);
                check("tie_rdata", 32'(p ? rdata1_v[k] : rdata0_v[k]), 32'(ref_mem[k][a[p][7:0]]));
                ref_last[k] = (p == 1);
                got++;
                since = 0;
                if (got == ndone) begin
                    set_port(k, 0, 1'b0, 1'b0, 16'h0, 16'h0);
                    set_port(k, 1, 1'b0, 1'b0, 16'h0, 16'h0);
                end
            end
        end
        check("tie_count", got, ndone);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int k);
        rstn_v[k] = 1'b0;
        repeat (2) @(negedge clk);
        rstn_v[k] = 1'b1;
        ref_last[k] = 1'b1;
    endtask

    initial begin
        ram_init = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rstn_v[k] = 1'b0;
            set_port(k, 0, 1'b0, 1'b0, 16'h0, 16'h0);
            set_port(k, 1, 1'b0, 1'b0, 16'h0, 16'h0);
            ref_last[k] = 1'b1;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(i);
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check_reset_outputs(k, "reset");
        ram_init = 1'b0;
        for (int k = 0; k < 3; k++) rstn_v[k] = 1'b1;
        @(negedge clk);

        // Single CPU read of the preset word, then AUX write followed by CPU read.
        txn(0, 0, 1'b0, 16'h0010, 16'h0);
        txn(0, 1, 1'b1, 16'h0020, 16'h1234);
        txn(0, 0, 1'b0, 16'h0020, 16'h0);

        // Ties from a fresh reset: alternate under round-robin, port0 always otherwise.
        do_reset(0);
        tie(0, 4);

        // Randomized single-requester traffic on the latency-1 arbiter.
        for (int i = 0; i < 30; i++) begin
            txn(0, int'($urandom_range(1)), 1'($urandom_range(1)),
                16'($urandom), 16'($urandom));
        end
        tie(0, 3);

        // Latency sweep on the 3- and 7-cycle arbiters.
        for (int k = 1; k < 3; k++) begin
            txn(k, 1, 1'b1, 16'h0040, 16'hA5C3);
            txn(k, 0, 1'b0, 16'h0040, 16'h0);
            txn(k, 0, 1'b0, 16'hF033, 16'h0);
            tie(k, 2);
        end

        // Reset during WAIT: outputs clear at once and no done appears.
        txn(1, 1, 1'b0, 16'h0033, 16'h0);
        set_port(1, 1, 1'b1, 1'b0, 16'h0044, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn_v[1] = 1'b0;
        #1;
        check_reset_outputs(1, "midreset");
        set_port(1, 1, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midreset_nodone", {30'd0, done1_v[1], done0_v[1]}, 0);
        end
        rstn_v[1] = 1'b1;
        ref_last[1] = 1'b1;
        @(negedge clk);
        txn(1, 1, 1'b0, 16'h0044, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
